// File: rtl/core_defs.sv
// Shared core definitions: datapath sizes, the x0 index and ALU control encodings
// used by the register file, the ALU and its control decoder.
package core_defs;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_ctrl_e;

  function automatic logic is_reg_zero(input logic [AW-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: x0 forces zero, a same-cycle write
// to the addressed register is forwarded, otherwise the stored value is selected.
module rf_read_port #(
  parameter int XLEN = core_defs::XLEN,
  parameter int NREG = core_defs::NREG,
  parameter int AW   = core_defs::AW
) (
  input  logic                 reset,
  input  logic [AW-1:0]        addr,
  input  logic                 reg_write,
  input  logic [AW-1:0]        rd_addr,
  input  logic [XLEN-1:0]      write_data,
  input  logic [NREG*XLEN-1:0] regs_flat,
  output logic [XLEN-1:0]      data
);
  import core_defs::*;

  logic            bypass_hit;
  logic [XLEN-1:0] stored;

  always_comb begin
    // Forwarding is blocked during reset so reads never see a doomed write.
    bypass_hit = reg_write && (rd_addr == addr) && !reset;
    stored     = regs_flat[int'(addr)*XLEN +: XLEN];
    if (is_reg_zero(addr)) begin
      data = '0;
    end else if (bypass_hit) begin
      data = write_data;
    end else begin
      data = stored;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit integer register file: two bypassed combinational read ports,
// one synchronous write port, x0 hardwired to zero, plus an unbypassed debug read.
module register_file #(
  parameter int XLEN = core_defs::XLEN,
  parameter int NREG = core_defs::NREG,
  parameter int AW   = core_defs::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic            RegWrite,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  import core_defs::*;

  if (AW != $clog2(NREG)) begin : g_bad_aw
    $error("register_file: AW must equal clog2(NREG)");
  end

  logic [XLEN-1:0]      regs [NREG];
  logic [NREG*XLEN-1:0] regs_flat;

  // Reset wins over a coincident write; x0 is never a write target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && !is_reg_zero(rd_addr)) begin
      regs[rd_addr] <= write_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = regs[g];
  end

  rf_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_port1 (
    .reset      (reset),
    .addr       (rs1_addr),
    .reg_write  (RegWrite),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .regs_flat  (regs_flat),
    .data       (rs1)
  );

  rf_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_port2 (
    .reset      (reset),
    .addr       (rs2_addr),
    .reg_write  (RegWrite),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .regs_flat  (regs_flat),
    .data       (rs2)
  );

  assign dbg_data = is_reg_zero(dbg_addr) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, x0, write/read, bypass, ALU round trip
// and reset/write interactions, with hand-computed expectations.
module tb_register_file;
  import core_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        RegWrite = 1'b0;
  logic [63:0] write_data = '0;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  dbg_addr = '0;
  logic [63:0] dbg_data;

  int tests = 0;
  int fails = 0;

  register_file dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .RegWrite   (RegWrite),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu(input logic [3:0] ctrl, input logic [63:0] a,
                                      input logic [63:0] b);
    case (ctrl)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return '0;
    endcase
  endfunction

  // Drives one write that lands on the next rising edge; returns at the following negedge.
  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    rd_addr    = a;
    write_data = d;
    RegWrite   = 1'b1;
    @(negedge clk);
    RegWrite   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    rs1_addr = 5'd9; rs2_addr = 5'd31; dbg_addr = 5'd17;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL reset_rs1 got %h want %h", rs1, 64'h0); end
    tests++; if (rs2 !== 64'h0) begin fails++; $display("FAIL reset_rs2 got %h want %h", rs2, 64'h0); end
    tests++; if (dbg_data !== 64'h0) begin fails++; $display("FAIL reset_dbg got %h want %h", dbg_data, 64'h0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_x0;
    do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL x0_rs1 got %h want %h", rs1, 64'h0); end
    tests++; if (rs2 !== 64'h0) begin fails++; $display("FAIL x0_rs2 got %h want %h", rs2, 64'h0); end
    tests++; if (dbg_data !== 64'h0) begin fails++; $display("FAIL x0_dbg got %h want %h", dbg_data, 64'h0); end
    // x0 must not be forwarded either
    rd_addr = 5'd0; write_data = 64'h1234; RegWrite = 1'b1;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL x0_bypass got %h want %h", rs1, 64'h0); end
    RegWrite = 1'b0;
  endtask

  task automatic test_write_read;
    do_write(5'd10, 64'h0123_4567_89AB_CDEF);
    rs1_addr = 5'd10; rs2_addr = 5'd10; dbg_addr = 5'd10;
    #1;
    tests++; if (rs1 !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL wr_rs1 got %h want %h", rs1, 64'h0123_4567_89AB_CDEF); end
    tests++; if (rs2 !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL wr_rs2 got %h want %h", rs2, 64'h0123_4567_89AB_CDEF); end
    tests++; if (dbg_data !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL wr_dbg got %h want %h", dbg_data, 64'h0123_4567_89AB_CDEF); end
    // RegWrite=0 leaves x10 alone despite rd_addr/write_data
    @(negedge clk);
    rd_addr = 5'd10; write_data = 64'hBAD0_BAD0_BAD0_BAD0; RegWrite = 1'b0;
    #1;
    tests++; if (rs1 !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL nowe_bypass got %h want %h", rs1, 64'h0123_4567_89AB_CDEF); end
    @(negedge clk);
    tests++; if (dbg_data !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL nowe_store got %h want %h", dbg_data, 64'h0123_4567_89AB_CDEF); end
  endtask

  task automatic test_bypass;
    do_write(5'd3, 64'h1);
    rd_addr = 5'd3; write_data = 64'h2; RegWrite = 1'b1;
    rs1_addr = 5'd3; rs2_addr = 5'd3; dbg_addr = 5'd3;
    #1;
    tests++; if (rs1 !== 64'h2) begin fails++; $display("FAIL byp_rs1 got %h want %h", rs1, 64'h2); end
    tests++; if (rs2 !== 64'h2) begin fails++; $display("FAIL byp_rs2 got %h want %h", rs2, 64'h2); end
    tests++; if (dbg_data !== 64'h1) begin fails++; $display("FAIL byp_dbg_old got %h want %h", dbg_data, 64'h1); end
    @(posedge clk); #1;
    tests++; if (dbg_data !== 64'h2) begin fails++; $display("FAIL byp_dbg_new got %h want %h", dbg_data, 64'h2); end
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    tests++; if (rs1 !== 64'h2) begin fails++; $display("FAIL byp_rs1_after got %h want %h", rs1, 64'h2); end
    // A write to another register must not be forwarded to x3
    rd_addr = 5'd4; write_data = 64'h77; RegWrite = 1'b1;
    #1;
    tests++; if (rs1 !== 64'h2) begin fails++; $display("FAIL byp_other got %h want %h", rs1, 64'h2); end
    RegWrite = 1'b0;
  endtask

  task automatic test_alu_roundtrip;
    logic [63:0] out;
    do_write(5'd1, 64'd7);
    do_write(5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    out = alu(ALU_SUB, rs1, rs2);
    do_write(5'd4, out);
    out = alu(ALU_ADD, rs1, rs2);
    do_write(5'd5, out);
    dbg_addr = 5'd4;
    #1;
    tests++; if (dbg_data !== 64'd10) begin fails++; $display("FAIL alu_sub_x4 got %h want %h", dbg_data, 64'd10); end
    dbg_addr = 5'd5;
    #1;
    tests++; if (dbg_data !== 64'd4) begin fails++; $display("FAIL alu_add_x5 got %h want %h", dbg_data, 64'd4); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 5'(11 + i); write_data = 64'hC0DE_0000_0000_0000 | 64'(i); RegWrite = 1'b1;
      @(negedge clk);
    end
    RegWrite = 1'b0;
    rs1_addr = 5'd11; rs2_addr = 5'd14; dbg_addr = 5'd12;
    #1;
    tests++; if (rs1 !== 64'hC0DE_0000_0000_0000) begin fails++; $display("FAIL b2b_x11 got %h want %h", rs1, 64'hC0DE_0000_0000_0000); end
    tests++; if (rs2 !== 64'hC0DE_0000_0000_0003) begin fails++; $display("FAIL b2b_x14 got %h want %h", rs2, 64'hC0DE_0000_0000_0003); end
    tests++; if (dbg_data !== 64'hC0DE_0000_0000_0001) begin fails++; $display("FAIL b2b_x12 got %h want %h", dbg_data, 64'hC0DE_0000_0000_0001); end
    dbg_addr = 5'd31;
    do_write(5'd31, 64'h8000_0000_0000_0001);
    tests++; if (dbg_data !== 64'h8000_0000_0000_0001) begin fails++; $display("FAIL x31 got %h want %h", dbg_data, 64'h8000_0000_0000_0001); end
  endtask

  task automatic test_reset_clears;
    do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
    rs1_addr = 5'd5; rs2_addr = 5'd5; dbg_addr = 5'd5;
    #1;
    tests++; if (rs1 !== 64'hDEAD_BEEF_0000_0001) begin fails++; $display("FAIL rc_pre got %h want %h", rs1, 64'hDEAD_BEEF_0000_0001); end
    #1 reset = 1'b1;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL rc_rs1 got %h want %h", rs1, 64'h0); end
    tests++; if (dbg_data !== 64'h0) begin fails++; $display("FAIL rc_dbg got %h want %h", dbg_data, 64'h0); end
    dbg_addr = 5'd10;
    #1;
    tests++; if (dbg_data !== 64'h0) begin fails++; $display("FAIL rc_x10 got %h want %h", dbg_data, 64'h0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_during_write;
    @(negedge clk);
    rd_addr = 5'd7; write_data = 64'hA5; RegWrite = 1'b1; reset = 1'b1;
    rs1_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL rdw_nobypass got %h want %h", rs1, 64'h0); end
    @(negedge clk);
    RegWrite = 1'b0; reset = 1'b0;
    #1;
    tests++; if (rs1 !== 64'h0) begin fails++; $display("FAIL rdw_rs1 got %h want %h", rs1, 64'h0); end
    tests++; if (dbg_data !== 64'h0) begin fails++; $display("FAIL rdw_dbg got %h want %h", dbg_data, 64'h0); end
    // First edge after release accepts a write
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rd_addr = 5'd8; write_data = 64'h55; RegWrite = 1'b1; dbg_addr = 5'd8;
    @(posedge clk); #1;
    tests++; if (dbg_data !== 64'h55) begin fails++; $display("FAIL rel_first got %h want %h", dbg_data, 64'h55); end
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_x0();
    test_write_read();
    test_bypass();
    test_alu_roundtrip();
    test_back_to_back();
    test_reset_clears();
    test_reset_during_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
